// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link deserializer.
// Contents:
//   - DEFAULT_WIDTH: the word width shared with the PISO transmitter.
//   - state_t: the receiver FSM states.
//   - count_width(): the bit-counter width for a given word width.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Returns the width needed to count 0..w-1, and never less than 1 bit.
  function automatic int count_width(input int w);
    int n;
    n = 0;
    while ((32'd1 << n) < w) begin
      n = n + 1;
    end
    if (n < 1) begin
      n = 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Bus between the serial line, the parallel consumer and the deserializer.
// Signals:
//   sin, sin_valid, frame_start : serial input side
//   out_ready, overrun_clr      : consumer-side controls
//   parallel_out, out_valid     : completed word and its valid flag
//   busy, overrun               : status
// Modports:
//   slave  : the deserializer's view
//   master : the view of the environment that drives the deserializer
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic             out_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  modport slave (
    input  sin, sin_valid, frame_start, out_ready, overrun_clr,
    output parallel_out, out_valid, busy, overrun
  );

  modport master (
    output sin, sin_valid, frame_start, out_ready, overrun_clr,
    input  parallel_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_out_reg.sv
// Valid/ready holding register with sticky overrun detection.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   word_done    : a complete word is offered this cycle on word_in
//   word_in      : the completed word
//   out_ready    : the consumer accepts the held word when out_valid is 1
//   overrun_clr  : clears the overrun flag
//   parallel_out : the held word (stable while out_valid is 1)
//   out_valid    : the held word has not been consumed yet
//   overrun      : sticky flag, a completed word was dropped
module sipo_out_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_done,
  input  logic [WIDTH-1:0] word_in,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_n;
  logic             valid_r;
  logic             valid_n;
  logic             overrun_r;
  logic             overrun_n;
  logic             can_load;

  // A slot can accept a new word if it is empty or is being drained on this edge.
  assign can_load = ~valid_r | out_ready;

  // Next-state logic for the holding register and the overrun flag.
  always_comb begin
    data_n    = data_r;
    valid_n   = valid_r;
    overrun_n = overrun_r;

    if (word_done && can_load) begin
      data_n  = word_in;
      valid_n = 1'b1;
    end else if (valid_r && out_ready) begin
      valid_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    // A dropped word sets the flag even if a clear is requested on the same edge.
    if (word_done && !can_load) begin
      overrun_n = 1'b1;
    end else if (overrun_clr) begin
      overrun_n = 1'b0;
    end else begin
      overrun_n = overrun_r;
    end
  end

  // Holding register and overrun flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      data_r    <= data_n;
      valid_r   <= valid_n;
      overrun_r <= overrun_n;
    end
  end

  assign parallel_out = data_r;
  assign out_valid    = valid_r;
  assign overrun      = overrun_r;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver for the PISO serial link.
// It samples sin on every clock edge where sin_valid is 1 and assembles
// WIDTH-bit words. Each completed word is offered to the valid/ready
// holding register. frame_start marks bit 0 and resynchronises the
// bit counter.
// Parameters:
//   WIDTH     : bits per word (2 or more)
//   MSB_FIRST : 1 = first bit lands in parallel_out[WIDTH-1], 0 = in bit 0
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave view of sipo_deserializer_if (serial in, word out, status)
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deserializer_if.slave   bus
);

  localparam int COUNT_W = count_width(WIDTH);
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_n;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_n;
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   shift_n;
  logic               busy_r;
  logic [COUNT_W-1:0] cur_idx;
  logic [WIDTH-1:0]   base;
  logic [WIDTH-1:0]   shifted;
  logic               word_done;
  logic [WIDTH-1:0]   word;

  // Shift/count FSM: works out where the current bit goes and whether it completes a word.
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    shift_n   = shift_r;
    word_done = 1'b0;
    word      = shift_r;

    // frame_start drops any partial word, so the current bit is bit 0.
    if (bus.frame_start || (state_r == IDLE)) begin
      cur_idx = {COUNT_W{1'b0}};
      base    = {WIDTH{1'b0}};
    end else begin
      cur_idx = count_r;
      base    = shift_r;
    end

    if (MSB_FIRST) begin
      shifted = {base[WIDTH-2:0], bus.sin};
    end else begin
      shifted = {bus.sin, base[WIDTH-1:1]};
    end

    if (bus.sin_valid) begin
      if (cur_idx == LAST_IDX) begin
        word_done = 1'b1;
        word      = shifted;
        count_n   = {COUNT_W{1'b0}};
        shift_n   = {WIDTH{1'b0}};
        state_n   = IDLE;
      end else begin
        count_n = cur_idx + COUNT_W'(1);
        shift_n = shifted;
        state_n = SHIFT;
      end
    end else if (bus.frame_start) begin
      count_n = {COUNT_W{1'b0}};
      shift_n = {WIDTH{1'b0}};
      state_n = IDLE;
    end else begin
      count_n = count_r;
      shift_n = shift_r;
      state_n = state_r;
    end
  end

  // FSM, counter, shift register and busy flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= {COUNT_W{1'b0}};
      shift_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      shift_r <= shift_n;
      busy_r  <= (count_n != {COUNT_W{1'b0}});
    end
  end

  logic [WIDTH-1:0] pout;
  logic             pvalid;
  logic             povr;

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .word_done    (word_done),
    .word_in      (word),
    .out_ready    (bus.out_ready),
    .overrun_clr  (bus.overrun_clr),
    .parallel_out (pout),
    .out_valid    (pvalid),
    .overrun      (povr)
  );

  assign bus.parallel_out = pout;
  assign bus.out_valid    = pvalid;
  assign bus.overrun      = povr;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed test of sipo_deserializer. Two instances (MSB_FIRST=1 and
// MSB_FIRST=0, WIDTH=3) receive identical stimulus. Checks are made 1 time
// unit after each rising edge.
module tb_sipo_deserializer;

  logic clk;
  logic rst;
  logic sin;
  logic sin_valid;
  logic frame_start;
  logic out_ready;
  logic overrun_clr;

  int n_assert;
  int n_fail;

  sipo_deserializer_if #(.WIDTH(3)) bus_m ();
  sipo_deserializer_if #(.WIDTH(3)) bus_l ();

  assign bus_m.sin         = sin;
  assign bus_m.sin_valid   = sin_valid;
  assign bus_m.frame_start = frame_start;
  assign bus_m.out_ready   = out_ready;
  assign bus_m.overrun_clr = overrun_clr;
  assign bus_l.sin         = sin;
  assign bus_l.sin_valid   = sin_valid;
  assign bus_l.frame_start = frame_start;
  assign bus_l.out_ready   = out_ready;
  assign bus_l.overrun_clr = overrun_clr;

  sipo_deserializer #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  sipo_deserializer #(.WIDTH(3), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic idle();
    sin_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    sin         = 1'b0;
    sin_valid   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    chk("rst_pout", {29'd0, bus_m.parallel_out}, 32'd0);
    chk("rst_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus_m.busy}, 32'd0);
    chk("rst_ovr", {31'd0, bus_m.overrun}, 32'd0);
    rst = 1'b0;

    // Word 0,0,1, one bit per cycle.
    out_ready = 1'b1;
    send_bit(1'b0);
    chk("t1_busy1", {31'd0, bus_m.busy}, 32'd1);
    send_bit(1'b0);
    chk("t1_valid_early", {31'd0, bus_m.out_valid}, 32'd0);
    send_bit(1'b1);
    chk("t1_pout_m", {29'd0, bus_m.parallel_out}, 32'h1);
    chk("t1_pout_l", {29'd0, bus_l.parallel_out}, 32'h4);
    chk("t1_valid", {31'd0, bus_m.out_valid}, 32'd1);
    chk("t1_busy0", {31'd0, bus_m.busy}, 32'd0);
    idle();
    chk("t1_drain_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("t1_drain_pout", {29'd0, bus_m.parallel_out}, 32'h1);

    // Back-to-back 1,0,0 then 1,0,1 with sin_valid held high.
    sin_valid = 1'b1;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b0; tick();
    chk("t2_w1_m", {29'd0, bus_m.parallel_out}, 32'h4);
    chk("t2_w1_l", {29'd0, bus_l.parallel_out}, 32'h1);
    chk("t2_w1_valid", {31'd0, bus_m.out_valid}, 32'd1);
    sin = 1'b1; tick();
    chk("t2_mid_valid", {31'd0, bus_m.out_valid}, 32'd0);
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin_valid = 1'b0;
    chk("t2_w2_m", {29'd0, bus_m.parallel_out}, 32'h5);
    chk("t2_w2_l", {29'd0, bus_l.parallel_out}, 32'h5);
    chk("t2_w2_valid", {31'd0, bus_m.out_valid}, 32'd1);
    chk("t2_ovr", {31'd0, bus_m.overrun}, 32'd0);
    idle();

    // Bits 1,0,0 with two idle cycles between bits.
    send_bit(1'b1);
    idle();
    idle();
    chk("t3_gap_busy", {31'd0, bus_l.busy}, 32'd1);
    send_bit(1'b0);
    idle();
    idle();
    chk("t3_gap_valid", {31'd0, bus_l.out_valid}, 32'd0);
    send_bit(1'b0);
    chk("t3_pout_l", {29'd0, bus_l.parallel_out}, 32'h1);
    chk("t3_valid_l", {31'd0, bus_l.out_valid}, 32'd1);
    chk("t3_pout_m", {29'd0, bus_m.parallel_out}, 32'h4);
    idle();

    // Word 1,1,0 held with out_ready=0, then 0,1,1 completes and is dropped.
    out_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t4_hold_m", {29'd0, bus_m.parallel_out}, 32'h6);
    chk("t4_hold_valid", {31'd0, bus_m.out_valid}, 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("t4_kept_m", {29'd0, bus_m.parallel_out}, 32'h6);
    chk("t4_kept_l", {29'd0, bus_l.parallel_out}, 32'h3);
    chk("t4_ovr_m", {31'd0, bus_m.overrun}, 32'd1);
    chk("t4_ovr_l", {31'd0, bus_l.overrun}, 32'd1);
    idle();
    chk("t4_ovr_sticky", {31'd0, bus_m.overrun}, 32'd1);
    overrun_clr = 1'b1;
    idle();
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", {31'd0, bus_m.overrun}, 32'd0);
    // A drop on the same edge as a clear request leaves the flag set.
    send_bit(1'b1);
    send_bit(1'b0);
    overrun_clr = 1'b1;
    send_bit(1'b1);
    overrun_clr = 1'b0;
    chk("t4_set_wins", {31'd0, bus_m.overrun}, 32'd1);
    out_ready = 1'b1;
    idle();
    chk("t4_drain_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("t4_drain_pout", {29'd0, bus_m.parallel_out}, 32'h6);

    // Partial 0,1 discarded by frame_start, then 1,1,1.
    send_bit(1'b0);
    send_bit(1'b1);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    chk("t5_fs_busy", {31'd0, bus_m.busy}, 32'd1);
    send_bit(1'b1);
    chk("t5_fs_valid", {31'd0, bus_m.out_valid}, 32'd0);
    send_bit(1'b1);
    chk("t5_pout_m", {29'd0, bus_m.parallel_out}, 32'h7);
    chk("t5_valid", {31'd0, bus_m.out_valid}, 32'd1);
    idle();
    // frame_start without sin_valid clears the partial word.
    send_bit(1'b1);
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
    chk("t5_fs_idle_busy", {31'd0, bus_m.busy}, 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t5_fs_idle_pout", {29'd0, bus_m.parallel_out}, 32'h2);
    idle();

    // Reset after two bits, then 1,0,1.
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_pout", {29'd0, bus_m.parallel_out}, 32'd0);
    chk("t6_rst_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus_m.busy}, 32'd0);
    tick();
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_valid_early", {31'd0, bus_m.out_valid}, 32'd0);
    send_bit(1'b1);
    chk("t6_pout_m", {29'd0, bus_m.parallel_out}, 32'h5);
    chk("t6_valid", {31'd0, bus_m.out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
